// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types for the MEM-stage access unit.
// Holds access sizes, FSM states, byte-lane masks and a lane helper.
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_e;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
   localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
   localparam logic [31:0] WORD_MASK = 32'hffff_ffff;

   // Aligned byte lane of an access; low bits that cannot
   // address the given size are dropped.
   function automatic logic [1:0] lane_of(
      input size_e      sz,
      input logic [1:0] a
   );
      logic [1:0] l;
      l = 2'b00;
      unique case (1'b1)
         sz == SZ_BYTE: l = a;
         sz == SZ_HALF: l = {a[1], 1'b0};
         default:       l = 2'b00;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: replaces one byte/half lane of a word with new data.
// Ports: oldWord, newData, size, lane in; merged out. Purely combinational.
module store_lane_merge
   import mem_access_pkg::*;
(
   input  logic [31:0] oldWord,
   input  logic [31:0] newData,
   input  size_e       size,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   logic [31:0] base;
   logic [31:0] mask;
   logic [4:0]  sh;

   always_comb begin
      base = WORD_MASK;
      unique case (1'b1)
         size == SZ_BYTE: base = BYTE_MASK;
         size == SZ_HALF: base = HALF_MASK;
         default:         base = WORD_MASK;
      endcase
      sh     = {lane, 3'b000};
      mask   = base << sh;
      merged = (oldWord & ~mask) | ((newData & base) << sh);
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage sub-word load/store adapter for a word memory.
// Ports: clk, reset, memRead, memWrite, accessSize, loadUnsigned, address,
// storeData, dmemReadData in; loadData, stall, dmemWrite, dmemAddress,
// dmemWriteData out; misaligned out only with MEM_MISALIGN_TRAP_EN.
// Sub-word stores take two cycles: capture the old word, then write merged.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int WORD_ADDR_BITS = 10,
   parameter int DATA_WIDTH     = 32
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [1:0]            accessSize,
   input  logic                  loadUnsigned,
   input  logic [31:0]           address,
   input  logic [DATA_WIDTH-1:0] storeData,
   output logic [DATA_WIDTH-1:0] loadData,
   output logic                  stall,
   output logic                  dmemWrite,
   output logic [31:0]           dmemAddress,
   output logic [DATA_WIDTH-1:0] dmemWriteData,
   input  logic [DATA_WIDTH-1:0] dmemReadData
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic                  misaligned
`endif
);

   if (DATA_WIDTH != 32) begin : g_bad_width
      $fatal(1, "mem_access_unit: DATA_WIDTH must be 32");
   end
   if (WORD_ADDR_BITS < 1 || WORD_ADDR_BITS > 30) begin : g_bad_addr
      $fatal(1, "mem_access_unit: WORD_ADDR_BITS out of range");
   end

   size_e       sz;
   logic        isWord;
   logic [1:0]  lane;
   state_e      state;
   logic        idle;
   logic        misal;
   logic        rmwStart;

   logic [29:0] capAddr;
   logic [1:0]  capLane;
   size_e       capSize;
   logic [31:0] capData;
   logic [31:0] capWord;
   logic [31:0] merged;

   logic [31:0] shifted;
   logic [31:0] ext;
   logic        sgn8;
   logic        sgn16;

   assign sz     = size_e'(accessSize);
   assign isWord = accessSize[1];
   assign lane   = lane_of(sz, address[1:0]);
   assign idle   = !reset && state == IDLE;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misal = idle && (memRead || memWrite) &&
                  ((sz == SZ_HALF && address[0]) ||
                   (isWord && address[1:0] != 2'b00));
   assign misaligned = misal;
`else
   assign misal = 1'b0;
`endif

   // A store wins over a simultaneous load.
   assign rmwStart = idle && memWrite && !isWord && !misal;

   store_lane_merge u_merge (
      .oldWord (capWord),
      .newData (capData),
      .size    (capSize),
      .lane    (capLane),
      .merged  (merged)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         capAddr <= '0;
         capLane <= '0;
         capSize <= SZ_BYTE;
         capData <= '0;
         capWord <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (rmwStart) begin
                  state   <= MERGE;
                  capAddr <= address[31:2];
                  capLane <= lane;
                  capSize <= sz;
                  capData <= storeData;
                  capWord <= dmemReadData;
               end
            end
            MERGE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // MERGE ignores the (still presented) request inputs.
   always_comb begin
      stall         = 1'b0;
      dmemWrite     = 1'b0;
      dmemAddress   = {address[31:2], 2'b00};
      dmemWriteData = storeData;
      if (state == MERGE) begin
         dmemAddress   = {capAddr, 2'b00};
         dmemWriteData = merged;
         dmemWrite     = !reset;
      end else begin
         stall     = rmwStart;
         dmemWrite = idle && memWrite && isWord && !misal;
      end
   end

   always_comb begin
      shifted = dmemReadData >> {lane, 3'b000};
      sgn8    = !loadUnsigned && shifted[7];
      sgn16   = !loadUnsigned && shifted[15];
      ext     = shifted;
      unique case (1'b1)
         sz == SZ_BYTE: ext = {{24{sgn8}}, shifted[7:0]};
         sz == SZ_HALF: ext = {{16{sgn16}}, shifted[15:0]};
         default:       ext = shifted;
      endcase
      loadData = '0;
      if (idle && memRead && !memWrite && !misal)
         loadData = ext;
   end

endmodule
